// File: rtl/fib_index_decoder_pkg.sv
// Shared constants and state encoding for the Fibonacci index decoder.
package fib_index_decoder_pkg;
  localparam int W         = 32;
  localparam int IW        = 8;
  localparam int FIB_MAX_K = 47;

  typedef enum logic [2:0] {
    R0 = 3'd0,
    R1 = 3'd1,
    C  = 3'd2,
    O0 = 3'd3,
    O1 = 3'd4
  } state_e;
endpackage

// File: rtl/fib_index_decoder_next_fibonacci_w.sv
// Next Fibonacci term: plain unsigned add with no carry-in.
module next_fibonacci_w #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] f_n_m1_i,
  input  logic [WIDTH-1:0] f_n_m2_i,
  output logic [WIDTH-1:0] f_n_o
);
  assign f_n_o = f_n_m1_i + f_n_m2_i;
endmodule

// File: rtl/fib_index_decoder.sv
// Accepts a word over dav_/rfd, walks the Fibonacci sequence until it reaches or
// passes the word, then offers the index and is_fib flag downstream.
module fib_index_decoder
  import fib_index_decoder_pkg::*;
(
  input  logic          clock,
  input  logic          reset_,
  input  logic          dav_in_,
  output logic          rfd_in,
  input  logic [W-1:0]  x,
  output logic          dav_out_,
  input  logic          rfd_out,
  output logic [IW-1:0] index,
  output logic          is_fib
);
  state_e        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W:0]    fm1_q, fm1_d, fm2_q, fm2_d;
  logic [W:0]    fib_sum;
  logic [W:0]    x_ext;
  logic [IW-1:0] k_q, k_d, index_q, index_d;
  logic          is_fib_q, is_fib_d, rfd_in_q, rfd_in_d, dav_out_q, dav_out_d;

  next_fibonacci_w #(.WIDTH(W + 1)) u_next_fib (
    .f_n_m1_i (fm1_q),
    .f_n_m2_i (fm2_q),
    .f_n_o    (fib_sum)
  );

  assign x_ext = {1'b0, x_q};

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    fm1_d     = fm1_q;
    fm2_d     = fm2_q;
    k_d       = k_q;
    index_d   = index_q;
    is_fib_d  = is_fib_q;
    rfd_in_d  = rfd_in_q;
    dav_out_d = dav_out_q;
    unique case (state_q)
      R0: begin
        if (!dav_in_) begin
          x_d      = x;
          rfd_in_d = 1'b0;
          state_d  = R1;
        end
      end
      R1: begin
        fm1_d = {{W{1'b0}}, 1'b1};
        fm2_d = '0;
        k_d   = IW'(1);
        if (dav_in_) begin
          rfd_in_d = 1'b1;
          if (x_q == '0) begin
            index_d   = '0;
            is_fib_d  = 1'b1;
            dav_out_d = 1'b0;
            state_d   = O0;
          end else begin
            state_d = C;
          end
        end
      end
      C: begin
        // dav_out_ drops on the exit edge so the result is valid on O0 entry
        if (fm1_q == x_ext) begin
          index_d   = k_q;
          is_fib_d  = 1'b1;
          dav_out_d = 1'b0;
          state_d   = O0;
        end else if (fm1_q > x_ext) begin
          index_d   = k_q - IW'(1);
          is_fib_d  = 1'b0;
          dav_out_d = 1'b0;
          state_d   = O0;
        end else begin
          fm1_d = fib_sum;
          fm2_d = fm1_q;
          k_d   = k_q + IW'(1);
        end
      end
      O0: begin
        if (!rfd_out) begin
          dav_out_d = 1'b1;
          state_d   = O1;
        end
      end
      O1: begin
        if (rfd_out) state_d = R0;
      end
      default: state_d = R0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q   <= R0;
      x_q       <= '0;
      fm1_q     <= '0;
      fm2_q     <= '0;
      k_q       <= '0;
      index_q   <= '0;
      is_fib_q  <= 1'b0;
      rfd_in_q  <= 1'b1;
      dav_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      fm1_q     <= fm1_d;
      fm2_q     <= fm2_d;
      k_q       <= k_d;
      index_q   <= index_d;
      is_fib_q  <= is_fib_d;
      rfd_in_q  <= rfd_in_d;
      dav_out_q <= dav_out_d;
    end
  end

  assign rfd_in   = rfd_in_q;
  assign dav_out_ = dav_out_q;
  assign index    = index_q;
  assign is_fib   = is_fib_q;
endmodule

// File: tb/tb_fib_index_decoder.sv
// Scoreboard bench: driver pushes reference results, monitor and sink check what the DUT returns.
module tb_fib_index_decoder;
  logic        clock = 1'b0;
  logic        reset_, dav_in_, rfd_in, dav_out_, rfd_out, is_fib;
  logic [31:0] x;
  logic [7:0]  index;

  always #5 clock = ~clock;

  fib_index_decoder dut (
    .clock    (clock),
    .reset_   (reset_),
    .dav_in_  (dav_in_),
    .rfd_in   (rfd_in),
    .x        (x),
    .dav_out_ (dav_out_),
    .rfd_out  (rfd_out),
    .index    (index),
    .is_fib   (is_fib)
  );

  typedef struct {
    int idx;
    int fib;
    int cyc;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   cur_exp;
  int     n_checks = 0;
  int     n_fail   = 0;
  longint fib_tab[0:48];
  int     hold_len = -1;
  int     neg_cnt  = 0;
  int     rise_t   = 0;
  logic   prev_rfd = 1'b1;
  logic   prev_dav = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: smallest k>=1 with F(k)>=x gives both the C-cycle count and the index.
  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    int   k;
    if (v == 32'd0) begin
      e.idx = 0; e.fib = 1; e.cyc = 0;
      return e;
    end
    k = 1;
    while (fib_tab[k] < longint'(v)) k++;
    e.cyc = k;
    if (fib_tab[k] == longint'(v)) begin
      e.idx = k; e.fib = 1;
    end else begin
      e.idx = k - 1; e.fib = 0;
    end
    return e;
  endfunction

  // Monitor: compare result when dav_out_ falls; latency counted from rfd_in rising.
  always @(negedge clock) begin
    exp_t e;
    neg_cnt++;
    if (rfd_in === 1'b1 && prev_rfd !== 1'b1) rise_t = neg_cnt;
    if (reset_ === 1'b1 && dav_out_ === 1'b0 && prev_dav === 1'b1) begin
      check("result_expected", longint'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("index", longint'(index), e.idx);
        check("is_fib", longint'(is_fib), e.fib);
        check("c_cycles", neg_cnt - rise_t, e.cyc);
        cur_exp = e;
      end
    end
    prev_rfd = rfd_in;
    prev_dav = dav_out_;
  end

  // Sink: random hold in O0, checking stability and that no new word is taken meanwhile.
  initial begin
    int h;
    int t;
    rfd_out = 1'b1;
    forever begin
      @(negedge clock);
      if (reset_ === 1'b1 && dav_out_ === 1'b0 && rfd_out === 1'b1) begin
        h = (hold_len >= 0) ? hold_len : int'($urandom_range(0, 3));
        hold_len = -1;
        for (int i = 0; i < h; i++) begin
          @(negedge clock);
          check("hold_dav_out", longint'(dav_out_), 0);
          check("hold_index", longint'(index), cur_exp.idx);
          check("hold_no_accept", longint'(rfd_in), 1);
        end
        rfd_out = 1'b0;
        t = 0;
        while (dav_out_ !== 1'b1 && t < 50) begin
          @(negedge clock);
          t++;
        end
        if (dav_out_ !== 1'b1) check("dav_out_release", longint'(dav_out_), 1);
        rfd_out = 1'b1;
      end
    end
  end

  task automatic send(input logic [31:0] v);
    int t;
    x = v;
    dav_in_ = 1'b0;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (rfd_in !== 1'b0 && t < 400);
    if (rfd_in !== 1'b0) begin
      check("accept_timeout", longint'(rfd_in), 0);
      dav_in_ = 1'b1;
      return;
    end
    sb_q.push_back(model(v));
    x = $urandom();
    dav_in_ = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dir_vals[7];
    logic [31:0] v;
    int          t;
    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int i = 2; i <= 48; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];
    dir_vals = '{32'd0, 32'd1, 32'd55, 32'd56, 32'd4, 32'd2971215073, 32'hFFFFFFFF};

    reset_  = 1'b0;
    dav_in_ = 1'b1;
    x       = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_rfd_in", longint'(rfd_in), 1);
    check("rst_dav_out", longint'(dav_out_), 1);
    check("rst_index", longint'(index), 0);
    check("rst_is_fib", longint'(is_fib), 0);
    reset_ = 1'b1;
    @(negedge clock);

    foreach (dir_vals[i]) send(dir_vals[i]);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: v = 32'(fib_tab[$urandom_range(0, 47)]);
        1: v = 32'(fib_tab[$urandom_range(1, 47)] + 1);
        default: v = $urandom();
      endcase
      send(v);
    end

    hold_len = 20;
    send(32'd13);
    send(32'd21);

    send(32'd832040);
    repeat (5) @(negedge clock);
    reset_ = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
    sb_q.delete();
    check("midc_rst_rfd_in", longint'(rfd_in), 1);
    check("midc_rst_dav_out", longint'(dav_out_), 1);
    check("midc_rst_index", longint'(index), 0);
    check("midc_rst_is_fib", longint'(is_fib), 0);
    send(32'd8);

    t = 0;
    while ((sb_q.size() > 0 || dav_out_ !== 1'b1 || rfd_out !== 1'b1) && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("drain_pending", sb_q.size(), 0);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
